vga_sync_decoder: RTL and testbench

Receive-side counterpart of the 640x480 timing generator. It takes a raw active-low hsync/vsync/blank stream and recovers the pixel position (hcount, vcount) for every input cycle. It verifies the stream against the nominal 800x524 raster, reports measured line and frame lengths, and asserts `locked` once the stream is stable. It sits at the front of any capture or loop-back path that consumes generator-style timing.

---
 rtl/vga_sync_decoder.sv | 158 +++++++++++++++
 tb/tb_vga_sync_decoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - recovers raster position, line/frame measurements and lock from sync inputs
module vga_sync_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int HSYNC_POS   = 656,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 524,
    parameter int VSYNC_POS   = 491,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       vclock,
    input  logic       reset_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       blank_in,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       pixel_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines
);
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [9:0] CNT_MAX = 10'h3ff;
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_POS  = 10'(HSYNC_POS);
    localparam logic [9:0] VS_POS  = 10'(VSYNC_POS);
    localparam logic [9:0] LOCK_N  = 10'(LOCK_FRAMES);

    state_t     state_q;
    logic       hs_prev_q, vs_prev_q, hs_seen_q, vs_seen_q;
    logic [9:0] h_q, v_q, good_q, cyc_q, line_cnt_q, line_len_q, frame_lines_q;
    logic       pixel_valid_q, frame_start_q, locked_q, sync_err_q;

    logic       hs_fall, vs_fall, hs_pred, vs_pred;
    logic       edge_err, blank_err, active_d, lock_d;
    logic [9:0] h_free, v_free, h_d, v_d, good_inc;

    always_comb begin
        hs_fall = hs_prev_q & ~hsync_in;
        vs_fall = vs_prev_q & ~vsync_in;
        if (h_q == H_LAST) begin
            h_free = 10'd0;
            v_free = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end else begin
            h_free = h_q + 10'd1;
            v_free = v_q;
        end
        hs_pred = (h_free == HS_POS);
        vs_pred = (h_free == 10'd0) && (v_free == VS_POS);
        // vsync realigns both axes, so it wins over a coincident hsync fall
        h_d       = vs_fall ? 10'd0 : (hs_fall ? HS_POS : h_free);
        v_d       = vs_fall ? VS_POS : v_free;
        active_d  = (h_d < H_ACT) && (v_d < V_ACT);
        edge_err  = (hs_fall != hs_pred) || (vs_fall != vs_pred);
        blank_err = (blank_in != !active_d);
        good_inc  = (good_q == CNT_MAX) ? good_q : good_q + 10'd1;
        case (state_q)
            VERIFY:  lock_d = !edge_err && vs_fall && (good_inc >= LOCK_N);
            LOCKED:  lock_d = !(edge_err || blank_err);
            default: lock_d = 1'b0;
        endcase
    end

    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= SEARCH;
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            hs_seen_q     <= 1'b0;
            vs_seen_q     <= 1'b0;
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            good_q        <= 10'd0;
            cyc_q         <= 10'd0;
            line_cnt_q    <= 10'd0;
            line_len_q    <= 10'd0;
            frame_lines_q <= 10'd0;
            pixel_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            hs_prev_q     <= hsync_in;
            vs_prev_q     <= vsync_in;
            h_q           <= h_d;
            v_q           <= v_d;
            locked_q      <= lock_d;
            pixel_valid_q <= lock_d && active_d;
            frame_start_q <= lock_d && (h_d == 10'd0) && (v_d == 10'd0);
            sync_err_q    <= 1'b0;

            case (state_q)
                SEARCH: begin
                    if (vs_fall) begin
                        state_q <= VERIFY;
                        good_q  <= 10'd0;
                    end
                end
                VERIFY: begin
                    if (edge_err) begin
                        sync_err_q <= 1'b1;
                        state_q    <= SEARCH;
                    end else if (vs_fall) begin
                        good_q <= good_inc;
                        if (lock_d) begin
                            state_q <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (!lock_d) begin
                        sync_err_q <= 1'b1;
                        state_q    <= VERIFY;
                        good_q     <= 10'd0;
                    end
                end
                default: state_q <= SEARCH;
            endcase

            // the first edge after reset has no predecessor, so it reports 0
            if (hs_fall) begin
                cyc_q      <= 10'd1;
                line_len_q <= hs_seen_q ? cyc_q : 10'd0;
                hs_seen_q  <= 1'b1;
            end else if (cyc_q != CNT_MAX) begin
                cyc_q <= cyc_q + 10'd1;
            end

            if (vs_fall) begin
                frame_lines_q <= vs_seen_q ? line_cnt_q : 10'd0;
                vs_seen_q     <= 1'b1;
                line_cnt_q    <= {9'd0, hs_fall};
            end else if (hs_fall && (line_cnt_q != CNT_MAX)) begin
                line_cnt_q <= line_cnt_q + 10'd1;
            end
        end
    end

    assign hcount      = h_q;
    assign vcount      = v_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - scoreboard bench for vga_sync_decoder on a reduced raster
module tb_vga_sync_decoder;
    localparam int HA = 16, HT = 24, HSP = 18, HSW = 3;
    localparam int VA = 6, VT = 10, VSP = 7, VSW = 2;
    localparam int FRAME = HT * VT;
    localparam int SKIP_H = 17;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic lk, err, pv, fs, chk;
    } exp_t;

    logic       vclock = 1'b0, reset_n = 1'b0;
    logic       hsync_in = 1'b1, vsync_in = 1'b1, blank_in = 1'b1;
    logic [9:0] hcount, vcount, line_len, frame_lines;
    logic       pixel_valid, frame_start, locked, sync_err;

    exp_t sb_q[$];
    int   gh = 0, gv = 0;
    bit   exp_lock = 0, exp_err = 0, chk_pos = 0;
    bit   kill_hs = 0, force_blank = 0, skip_pending = 0;
    int   n_cmp = 0, n_bad = 0;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .HSYNC_POS(HSP),
        .V_ACTIVE(VA), .V_TOTAL(VT), .VSYNC_POS(VSP), .LOCK_FRAMES(2)
    ) dut (
        .vclock(vclock), .reset_n(reset_n),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .hcount(hcount), .vcount(vcount), .pixel_valid(pixel_valid),
        .frame_start(frame_start), .locked(locked), .sync_err(sync_err),
        .line_len(line_len), .frame_lines(frame_lines)
    );

    always #5 vclock = ~vclock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Drive one generator sample, queue its expected decode, advance the raster, pop after the edge.
    task automatic step(output exp_t got);
        exp_t e;
        hsync_in = kill_hs ? 1'b1 : !(gh >= HSP && gh < HSP + HSW);
        vsync_in = !(gv >= VSP && gv < VSP + VSW);
        blank_in = force_blank ? 1'b1 : !(gh < HA && gv < VA);
        e.h   = 10'(gh);
        e.v   = 10'(gv);
        e.lk  = exp_lock;
        e.err = exp_err;
        e.pv  = exp_lock && (gh < HA) && (gv < VA);
        e.fs  = exp_lock && (gh == 0) && (gv == 0);
        e.chk = chk_pos;
        sb_q.push_back(e);
        if (skip_pending && gh == SKIP_H - 1) begin
            gh = gh + 2;
            skip_pending = 0;
        end else begin
            gh = gh + 1;
        end
        if (gh >= HT) begin
            gh = 0;
            gv = (gv == VT - 1) ? 0 : gv + 1;
        end
        @(posedge vclock);
        #1;
        got = sb_q.pop_front();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge vclock);
        #1;
        n_cmp++; if (hcount !== 10'd0) begin n_bad++; $display("FAIL rst_hcount got %0d exp 0", hcount); end
        n_cmp++; if (vcount !== 10'd0) begin n_bad++; $display("FAIL rst_vcount got %0d exp 0", vcount); end
        n_cmp++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL rst_pv got %b exp 0", pixel_valid); end
        n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL rst_fs got %b exp 0", frame_start); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked got %b exp 0", locked); end
        n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b exp 0", sync_err); end
        n_cmp++; if (line_len !== 10'd0) begin n_bad++; $display("FAIL rst_line_len got %0d exp 0", line_len); end
        n_cmp++; if (frame_lines !== 10'd0) begin n_bad++; $display("FAIL rst_frame_lines got %0d exp 0", frame_lines); end
        reset_n = 1'b1;
        gh = 0;
        gv = 0;
    endtask

    task automatic test_acquire();
        exp_t e;
        int   nvs = 0;
        bit   vs_now;
        exp_lock = 0;
        chk_pos  = 0;
        for (int c = 0; c < 4 * FRAME && nvs < 3; c++) begin
            vs_now = (gh == 0 && gv == VSP);
            if (vs_now) begin
                nvs++;
                chk_pos = 1;
                if (nvs == 3) exp_lock = 1;
            end
            step(e);
            n_cmp++; if (sync_err !== e.err) begin n_bad++; $display("FAIL acq_err (%0d,%0d) got %b exp %b", e.h, e.v, sync_err, e.err); end
            n_cmp++; if (locked !== e.lk) begin n_bad++; $display("FAIL acq_locked (%0d,%0d) got %b exp %b", e.h, e.v, locked, e.lk); end
            n_cmp++; if (pixel_valid !== e.pv) begin n_bad++; $display("FAIL acq_pv (%0d,%0d) got %b exp %b", e.h, e.v, pixel_valid, e.pv); end
            if (e.chk) begin
                n_cmp++; if (hcount !== e.h || vcount !== e.v) begin n_bad++; $display("FAIL acq_pos got (%0d,%0d) exp (%0d,%0d)", hcount, vcount, e.h, e.v); end
            end
            if (vs_now && nvs == 1) begin
                n_cmp++; if (frame_lines !== 10'd0) begin n_bad++; $display("FAIL acq_first_frame_lines got %0d exp 0", frame_lines); end
            end
        end
        n_cmp++; if (nvs != 3) begin n_bad++; $display("FAIL acq_timeout vsync falls %0d exp 3", nvs); end
        n_cmp++; if (line_len !== 10'(HT)) begin n_bad++; $display("FAIL acq_line_len got %0d exp %0d", line_len, HT); end
        n_cmp++; if (frame_lines !== 10'(VT)) begin n_bad++; $display("FAIL acq_frame_lines got %0d exp %0d", frame_lines, VT); end
    endtask

    task automatic test_locked_stream();
        exp_t e;
        int   nfs = 0;
        exp_lock = 1;
        chk_pos  = 1;
        for (int c = 0; c < FRAME; c++) begin
            step(e);
            if (frame_start === 1'b1) nfs++;
            n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL lk_err (%0d,%0d) got %b exp 0", e.h, e.v, sync_err); end
            n_cmp++; if (locked !== e.lk) begin n_bad++; $display("FAIL lk_locked (%0d,%0d) got %b exp %b", e.h, e.v, locked, e.lk); end
            n_cmp++; if (pixel_valid !== e.pv) begin n_bad++; $display("FAIL lk_pv (%0d,%0d) got %b exp %b", e.h, e.v, pixel_valid, e.pv); end
            n_cmp++; if (frame_start !== e.fs) begin n_bad++; $display("FAIL lk_fs (%0d,%0d) got %b exp %b", e.h, e.v, frame_start, e.fs); end
            n_cmp++; if (hcount !== e.h || vcount !== e.v) begin n_bad++; $display("FAIL lk_pos got (%0d,%0d) exp (%0d,%0d)", hcount, vcount, e.h, e.v); end
            if (e.h == 10'(HA - 1) && e.v == 10'(VA - 1)) begin
                n_cmp++; if (pixel_valid !== 1'b1) begin n_bad++; $display("FAIL lk_last_pixel got %b exp 1", pixel_valid); end
            end
            if (e.h == 10'(HA) && e.v == 10'(VA - 1)) begin
                n_cmp++; if (hcount !== 10'(HA) || pixel_valid !== 1'b0) begin n_bad++; $display("FAIL lk_after_active got h=%0d pv=%b exp h=%0d pv=0", hcount, pixel_valid, HA); end
            end
        end
        n_cmp++; if (nfs != 1) begin n_bad++; $display("FAIL lk_fs_count got %0d exp 1", nfs); end
    endtask

    task automatic test_short_line();
        exp_t e;
        int   nvs = 0;
        bit   hit = 0, err_now, vs_now;
        exp_lock = 1;
        chk_pos  = 1;
        for (int c = 0; c < 4 * FRAME && nvs < 2; c++) begin
            if (!hit && gh == 0 && gv == 2) skip_pending = 1;
            err_now = !hit && gv == 2 && gh == HSP;
            vs_now  = hit && gh == 0 && gv == VSP;
            if (err_now) begin hit = 1; exp_err = 1; exp_lock = 0; end
            if (vs_now) begin nvs++; if (nvs == 2) exp_lock = 1; end
            step(e);
            n_cmp++; if (sync_err !== e.err) begin n_bad++; $display("FAIL short_err (%0d,%0d) got %b exp %b", e.h, e.v, sync_err, e.err); end
            n_cmp++; if (locked !== e.lk) begin n_bad++; $display("FAIL short_locked (%0d,%0d) got %b exp %b", e.h, e.v, locked, e.lk); end
            n_cmp++; if (pixel_valid !== e.pv) begin n_bad++; $display("FAIL short_pv (%0d,%0d) got %b exp %b", e.h, e.v, pixel_valid, e.pv); end
            n_cmp++; if (hcount !== e.h || vcount !== e.v) begin n_bad++; $display("FAIL short_pos got (%0d,%0d) exp (%0d,%0d)", hcount, vcount, e.h, e.v); end
            if (err_now) begin
                n_cmp++; if (line_len !== 10'(HT - 1)) begin n_bad++; $display("FAIL short_line_len got %0d exp %0d", line_len, HT - 1); end
            end
            exp_err = 0;
        end
        n_cmp++; if (nvs != 2) begin n_bad++; $display("FAIL short_timeout relock falls %0d exp 2", nvs); end
    endtask

    task automatic test_missing_hsync();
        exp_t e;
        int   nvs = 0, phase = 0;
        bit   err_now, vs_now;
        exp_lock = 1;
        chk_pos  = 1;
        for (int c = 0; c < 4 * FRAME && nvs < 2; c++) begin
            if (phase == 0 && gh == 0 && gv == 3) phase = 1;
            if (phase == 1 && gv != 3) phase = 2;
            kill_hs = (phase == 1);
            err_now = (phase == 1) && gh == HSP;
            vs_now  = (phase == 2) && gh == 0 && gv == VSP;
            if (err_now) begin exp_err = 1; exp_lock = 0; end
            if (vs_now) begin nvs++; if (nvs == 2) exp_lock = 1; end
            step(e);
            n_cmp++; if (sync_err !== e.err) begin n_bad++; $display("FAIL nohs_err (%0d,%0d) got %b exp %b", e.h, e.v, sync_err, e.err); end
            n_cmp++; if (locked !== e.lk) begin n_bad++; $display("FAIL nohs_locked (%0d,%0d) got %b exp %b", e.h, e.v, locked, e.lk); end
            n_cmp++; if (hcount !== e.h || vcount !== e.v) begin n_bad++; $display("FAIL nohs_pos got (%0d,%0d) exp (%0d,%0d)", hcount, vcount, e.h, e.v); end
            if (vs_now) begin
                n_cmp++;
                if (frame_lines !== 10'((nvs == 1) ? VT - 1 : VT)) begin
                    n_bad++; $display("FAIL nohs_frame_lines fall %0d got %0d exp %0d", nvs, frame_lines, (nvs == 1) ? VT - 1 : VT);
                end
            end
            exp_err = 0;
        end
        kill_hs = 0;
        n_cmp++; if (nvs != 2) begin n_bad++; $display("FAIL nohs_timeout relock falls %0d exp 2", nvs); end
    endtask

    task automatic test_blank_glitch();
        exp_t e;
        int   nvs = 0;
        bit   hit = 0, err_now, vs_now;
        exp_lock = 1;
        chk_pos  = 1;
        for (int c = 0; c < 4 * FRAME && nvs < 2; c++) begin
            err_now     = !hit && gh == 5 && gv == 2;
            vs_now      = hit && gh == 0 && gv == VSP;
            force_blank = err_now;
            if (err_now) begin hit = 1; exp_err = 1; exp_lock = 0; end
            if (vs_now) begin nvs++; if (nvs == 2) exp_lock = 1; end
            step(e);
            n_cmp++; if (sync_err !== e.err) begin n_bad++; $display("FAIL blank_err (%0d,%0d) got %b exp %b", e.h, e.v, sync_err, e.err); end
            n_cmp++; if (locked !== e.lk) begin n_bad++; $display("FAIL blank_locked (%0d,%0d) got %b exp %b", e.h, e.v, locked, e.lk); end
            n_cmp++; if (pixel_valid !== e.pv) begin n_bad++; $display("FAIL blank_pv (%0d,%0d) got %b exp %b", e.h, e.v, pixel_valid, e.pv); end
            exp_err = 0;
        end
        force_blank = 0;
        n_cmp++; if (nvs != 2) begin n_bad++; $display("FAIL blank_timeout relock falls %0d exp 2", nvs); end
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        int   nvs = 0;
        bit   vs_now;
        exp_lock = 1;
        chk_pos  = 1;
        for (int c = 0; c < 2 * FRAME && !(gh == 5 && gv == 4); c++) step(e);
        reset_n = 1'b0;
        #2;
        n_cmp++; if (hcount !== 10'd0 || vcount !== 10'd0) begin n_bad++; $display("FAIL mid_rst_pos got (%0d,%0d) exp (0,0)", hcount, vcount); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL mid_rst_locked got %b exp 0", locked); end
        n_cmp++; if (pixel_valid !== 1'b0 || frame_start !== 1'b0 || sync_err !== 1'b0) begin n_bad++; $display("FAIL mid_rst_flags got pv=%b fs=%b err=%b exp 0", pixel_valid, frame_start, sync_err); end
        n_cmp++; if (line_len !== 10'd0 || frame_lines !== 10'd0) begin n_bad++; $display("FAIL mid_rst_meas got %0d/%0d exp 0/0", line_len, frame_lines); end
        exp_lock = 0;
        chk_pos  = 0;
        repeat (3) begin
            step(e);
            n_cmp++; if (locked !== 1'b0 || hcount !== 10'd0) begin n_bad++; $display("FAIL mid_rst_hold got lk=%b h=%0d exp 0", locked, hcount); end
        end
        reset_n = 1'b1;
        for (int c = 0; c < 4 * FRAME && nvs < 3; c++) begin
            vs_now = (gh == 0 && gv == VSP);
            if (vs_now) begin
                nvs++;
                chk_pos = 1;
                if (nvs == 3) exp_lock = 1;
            end
            step(e);
            n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL mid_err (%0d,%0d) got %b exp 0", e.h, e.v, sync_err); end
            n_cmp++; if (locked !== e.lk) begin n_bad++; $display("FAIL mid_locked (%0d,%0d) got %b exp %b", e.h, e.v, locked, e.lk); end
            if (e.chk) begin
                n_cmp++; if (hcount !== e.h || vcount !== e.v) begin n_bad++; $display("FAIL mid_pos got (%0d,%0d) exp (%0d,%0d)", hcount, vcount, e.h, e.v); end
            end
            if (vs_now && nvs == 1) begin
                n_cmp++; if (frame_lines !== 10'd0) begin n_bad++; $display("FAIL mid_first_frame_lines got %0d exp 0", frame_lines); end
            end
        end
        n_cmp++; if (nvs != 3) begin n_bad++; $display("FAIL mid_timeout vsync falls %0d exp 3", nvs); end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_locked_stream();
        test_short_line();
        test_missing_hsync();
        test_blank_glitch();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
